// File: rtl/pipe_drain_pkg.sv
// ============================================================================
// Module   : pipe_drain_pkg
// Purpose  : Default sizing constants and width helper for pipe_drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_drain_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_TICK_DIV = 125000000;

    // Width able to hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_drain_if.sv
// ============================================================================
// Module   : pipe_drain_if
// Purpose  : Upstream handshake and slow-side outputs of pipe_drain.
//            PIPE_DRAIN_UNDERRUN_EN adds the sticky underrun flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_drain_if
    import pipe_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = count_w(DEPTH);

    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] count;
`ifdef PIPE_DRAIN_UNDERRUN_EN
    logic             underrun;

    modport master (output s_valid, s_data,
                    input  s_ready, q, q_valid, count, underrun);
    modport slave  (input  s_valid, s_data,
                    output s_ready, q, q_valid, count, underrun);
`else
    modport master (output s_valid, s_data,
                    input  s_ready, q, q_valid, count);
    modport slave  (input  s_valid, s_data,
                    output s_ready, q, q_valid, count);
`endif

endinterface

`default_nettype wire

// File: rtl/pipe_drain_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running prescaler; one-cycle tick every TICK_DIV clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    output logic      tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;

    assign tick = (tick_cnt_q == c_last_cnt);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_drain.sv
// ============================================================================
// Module   : pipe_drain
// Purpose  : FIFO-buffered pipeline sink releasing one word per prescaler tick.
//            Optional sticky underrun flag: define PIPE_DRAIN_UNDERRUN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_drain
    import pipe_drain_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pipe_drain_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_w(DEPTH);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;

    logic w_tick;
    logic w_push;
    logic w_pop;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Ready depends only on the registered count so upstream sees no comb loop.
    assign bus.s_ready = !rst && (count_q != c_full);
    assign w_push      = bus.s_valid && bus.s_ready;
    assign w_pop       = w_tick && (count_q != '0);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (w_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            q_d       = mem_q[rptr_q];
            rptr_d    = rptr_q + PTR_W'(1);
            q_valid_d = 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= bus.s_data;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.count   = count_q;

`ifdef PIPE_DRAIN_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q | (w_tick && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign bus.underrun = underrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_drain.sv
// ============================================================================
// Module   : tb_pipe_drain
// Purpose  : Self-checking bench for pipe_drain (WIDTH=4, DEPTH=4, TICK_DIV=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_drain;
    import pipe_drain_pkg::*;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_drain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pipe_drain #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a word queue plus cycles elapsed since reset.
    logic [WIDTH-1:0] m_q [$];
    logic [WIDTH-1:0] m_out = '0;
    bit               m_qv  = 1'b0;
    int               m_cyc = 0;
    bit               m_und = 1'b0;
    logic [WIDTH-1:0] released [$];

    typedef struct {
        bit         r;
        bit         v;
        logic [3:0] d;
        logic [3:0] eq;
        bit         eqv;
        int         ecnt;
        bit         erdy;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] d, output bit rdy);
        bit exp_rdy;
        bit tick;
        rst         = r;
        bus.s_valid = v;
        bus.s_data  = d;
        #1;
        exp_rdy = !r && (m_q.size() != DEPTH);
        rdy     = bus.s_ready;
        check("s_ready", bus.s_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_out = '0;
            m_qv  = 1'b0;
            m_cyc = 0;
            m_und = 1'b0;
        end else begin
            tick  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
            m_cyc = m_cyc + 1;
            m_qv  = 1'b0;
            if (tick) begin
                if (m_q.size() > 0) begin
                    m_out = m_q.pop_front();
                    m_qv  = 1'b1;
                end else begin
                    m_und = 1'b1;
                end
            end
            if (v && exp_rdy) m_q.push_back(d);
        end
        #1;
        check("q", bus.q, m_out);
        check("q_valid", bus.q_valid, m_qv);
        check("count", bus.count, m_q.size());
`ifdef PIPE_DRAIN_UNDERRUN_EN
        check("underrun", bus.underrun, m_und);
`endif
        if (bus.q_valid === 1'b1) released.push_back(bus.q);
    endtask

    task automatic idle(input int n);
        bit rdy;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        bit rdy;
        cycle(1'b1, 1'b0, '0, rdy);
        released.delete();
    endtask

    // Holds the word on the bus until accepted; reports refused cycles.
    task automatic offer(input logic [WIDTH-1:0] d, output int waited);
        bit rdy;
        waited = 0;
        for (int k = 0; k < 3 * TICK_DIV; k++) begin
            cycle(1'b0, 1'b1, d, rdy);
            if (rdy) return;
            waited++;
        end
        check("offer_accepted", 0, 1);
    endtask

    function automatic vec_t mk(bit r, bit v, logic [3:0] d, logic [3:0] eq, bit eqv, int ecnt, bit erdy);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.eq = eq; t.eqv = eqv; t.ecnt = ecnt; t.erdy = erdy;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rdy;
        int wt;
        logic [3:0] exp_order [$];

        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset + 12 idle cycles, then reset and two pushes released on ticks c3 and c7.
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
        for (int i = 0; i < 12; i++) tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h3, 4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4'hA, 4'h0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 4'h0, 4'h3, 1, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'h0, 4'h3, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'h0, 4'hA, 1, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 4'h0, 4'hA, 0, 0, 1));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].d, rdy);
            check($sformatf("tbl%0d_ready", i), rdy, tbl[i].erdy);
            check($sformatf("tbl%0d_q", i), bus.q, tbl[i].eq);
            check($sformatf("tbl%0d_qv", i), bus.q_valid, tbl[i].eqv);
            check($sformatf("tbl%0d_cnt", i), bus.count, tbl[i].ecnt);
        end

        // Overfill: words 1..6 back-to-back; the FIFO fills, word 6 waits past tick c7.
        do_reset();
        for (int w = 1; w <= 6; w++) begin
            offer(4'(w), wt);
            if (w == 5) check("w5_wait", wt, 0);
            if (w == 6) check("w6_wait", wt, 3);
        end
        idle(24);
        check("order_len", released.size(), 6);
        for (int i = 0; i < 6 && i < released.size(); i++)
            check($sformatf("order_%0d", i), released[i], i + 1);

        // Push on the same edge as a pop with count=2.
        do_reset();
        idle(1);
        cycle(1'b0, 1'b1, 4'h1, rdy);
        cycle(1'b0, 1'b1, 4'h2, rdy);
        cycle(1'b0, 1'b1, 4'h3, rdy);
        check("pushpop_count", bus.count, 2);
        check("pushpop_qv", bus.q_valid, 1);
        idle(12);
        exp_order = '{4'h1, 4'h2, 4'h3};
        check("pp_len", released.size(), 3);
        for (int i = 0; i < 3 && i < released.size(); i++)
            check($sformatf("pp_order_%0d", i), released[i], exp_order[i]);

        // Reset mid-prescale with three words buffered; next tick finds nothing.
        do_reset();
        cycle(1'b0, 1'b1, 4'h5, rdy);
        cycle(1'b0, 1'b1, 4'h6, rdy);
        cycle(1'b0, 1'b1, 4'h7, rdy);
        check("pre_rst_count", bus.count, 3);
        do_reset();
        check("rst_count", bus.count, 0);
        check("rst_q", bus.q, 0);
        check("rst_qv", bus.q_valid, 0);
        idle(4);
        check("rst_no_pop", released.size(), 0);
`ifdef PIPE_DRAIN_UNDERRUN_EN
        check("und_set", bus.underrun, 1);
        cycle(1'b0, 1'b1, 4'h9, rdy);
        idle(8);
        check("und_sticky", bus.underrun, 1);
        do_reset();
        check("und_cleared", bus.underrun, 0);
`endif

        // Randomized traffic with occasional resets, busy phase then sparse phase.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit r, v;
            r = ($urandom_range(0, 59) == 0);
            v = (i < 200) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25);
            cycle(r, v, 4'($urandom_range(0, 15)), rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_drain.md
# pipe_drain

Receiving end of the team's registered data pipelines. Accepts WIDTH-bit words from an upstream pipeline over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Releases one word per clock-enable tick from an internal prescaler counter. Sits between a full-rate pipeline and slow consumers (LEDs, displays, UART formatters) that sample on a tick.

## Interface
- WIDTH, 4, data word width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- TICK_DIV, 125000000, clock cycles per release tick; ≥2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  upstream word present
- s_data  in  WIDTH  upstream word
- s_ready  out  1  buffer can accept a word this cycle
- q  out  WIDTH  last released word, registered
- q_valid  out  1  one-cycle pulse, q updated this cycle
- count  out  $clog2(DEPTH+1)  words currently buffered

## Operation
- Push: edge with s_valid && s_ready writes s_data at the write pointer; wptr increments mod DEPTH; count +1.
- s_ready = !rst && (count != DEPTH); combinational from registered count only. There is no path from s_valid or tick to s_ready.
- Prescaler: tick_cnt counts 0..TICK_DIV-1, then wraps to 0. tick = (tick_cnt == TICK_DIV-1), a single-cycle strobe.
- Pop: edge with tick && count != 0 loads q from the head entry, rptr +1 mod DEPTH, count −1, q_valid=1 next cycle.
- Tick with count == 0: q holds its value, q_valid=0, and the tick is lost. There is no deferred pop.
- Simultaneous push and pop (count ≠ 0, ≠ DEPTH): count is unchanged, both pointers advance.
- Full: s_ready=0. A tick at full pops, and s_ready is 1 in the following cycle.
- Word order is strictly FIFO. A word pushed at edge N is poppable by a tick at edge ≥ N+1; there is no fall-through.
- count arithmetic is unsigned. It never exceeds DEPTH and never wraps below 0. Pointers use $clog2(DEPTH) bits with natural wrap.
- Reset (any cycle, including mid-burst or on a tick cycle): tick_cnt=0, wptr=rptr=0, count=0, q=0, q_valid=0. Buffered words are discarded. s_ready=0 while rst is high and 1 on the first cycle after.

## Timing
- Reset values: q=0, q_valid=0, count=0, s_ready=0 during reset, s_ready=1 the cycle after reset.
- After rst deasserts, the first tick is at the edge ending cycle TICK_DIV-1, then every TICK_DIV cycles.
- Pop latency: q/q_valid change on the tick edge and are visible 1 cycle after tick_cnt == TICK_DIV-1.
- q_valid is high for exactly one cycle per pop.
- s_ready reflects count after the previous edge. A word offered at full waits with no loss, provided upstream holds s_valid/s_data.

## Configuration
- PIPE_DRAIN_UNDERRUN_EN defined:
  - adds output underrun (1 bit), sticky.
  - underrun sets on any tick with count == 0 and clears only on rst.
  - the first tick after reset is counted when the FIFO is empty.
- PIPE_DRAIN_UNDERRUN_EN undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Package pipe_drain_pkg:
  - default WIDTH/DEPTH/TICK_DIV localparams.
  - function for the count width ($clog2(DEPTH+1)).
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick) holds the prescaler counter. The top holds the FIFO storage, pointers, count and the q register.

## Test plan
Bench parameters: WIDTH=4, DEPTH=4, TICK_DIV=4.
1. Reset then idle 12 cycles -> q=0, count=0, q_valid never high, s_ready=1 after reset.
2. Push 0x3, 0xA on consecutive cycles -> count=2. The next two ticks give q=0x3 then 0xA, each with a 1-cycle q_valid pulse, 4 cycles apart.
3. Push 5 words 1..5 back-to-back with no tick before the 4th push -> s_ready=0 after 4 accepted. Word 5 is accepted the cycle after the next tick. Release order is 1,2,3,4,5.
4. Push on the same edge as a pop (count=2) -> count stays 2 and ordering is preserved.
5. Assert rst for 1 cycle with count=3, mid-prescale -> count=0, q=0, q_valid=0. The first tick arrives 4 cycles after release and pops nothing.
6. With PIPE_DRAIN_UNDERRUN_EN: a tick with the FIFO empty -> underrun=1 and stays 1 through later pushes/pops. rst -> 0.
